a0_uart_tx: RTL and testbench

Consumes the `a0` result register exported by the pipelined RISC-V core on the FPGA build and streams each new value to a host as ASCII hex over an 8N1 UART line. Each message is 8 uppercase hex characters, MSB nibble first, followed by CR and LF. Value changes that arrive while a message is in flight are coalesced, so the most recent value always gets sent.

---
 rtl/a0_uart_tx.sv | 143 ++++++++++++++
 tb/tb_a0_uart_tx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/a0_uart_tx.sv
// Streams every new value of the core's a0 register to a host as 8 uppercase
// hex digits plus CR LF over an 8N1 UART; changes during a message are coalesced.
module a0_uart_tx #(
    parameter int DATA_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] a0,
    output logic                  tx,
    output logic                  busy,
    output logic                  dropped
);

    localparam int               CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [3:0]            char_idx_q, char_idx_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0] msg_q, msg_d;
    logic [DATA_WIDTH-1:0] prev_q, pend_val_q;
    logic                  pending_q, pending_d;
    logic                  dropped_q, dropped_d;
    logic                  tx_q, tx_d;
    logic                  changed, load, bit_done;
    logic [7:0]            char_d;

    // Characters 0..7 are the hex digits MSB nibble first, 8 is CR, 9 is LF.
    function automatic logic [7:0] char_at(input logic [DATA_WIDTH-1:0] m,
                                           input logic [3:0]            idx);
        logic [DATA_WIDTH-1:0] sh;
        logic [3:0]            nib;
        sh  = m << {idx[2:0], 2'b00};
        nib = sh[DATA_WIDTH-1 -: 4];
        if (idx == 4'd8)      return 8'h0D;
        else if (idx == 4'd9) return 8'h0A;
        else if (nib <= 4'd9) return 8'h30 + {4'h0, nib};
        else                  return 8'h37 + {4'h0, nib};
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        char_idx_d = char_idx_q;
        bit_idx_d  = bit_idx_q;
        msg_d      = msg_q;
        changed    = (a0 != prev_q);
        load       = (state_q == IDLE) && pending_q;
        bit_done   = (cnt_q == CNT_MAX);

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    state_d    = START;
                    msg_d      = pend_val_q;
                    char_idx_d = 4'd0;
                    bit_idx_d  = 3'd0;
                    cnt_d      = '0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (char_idx_q == 4'd9) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = START;
                        char_idx_d = char_idx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A change on the load edge re-arms pending with the newer value.
        pending_d = changed ? 1'b1 : (load ? 1'b0 : pending_q);
        dropped_d = changed && pending_q && !load;

        // The line level is computed from the next state so tx leaves a flop.
        char_d = char_at(msg_d, char_idx_d);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = char_d[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            char_idx_q <= 4'd0;
            bit_idx_q  <= 3'd0;
            msg_q      <= '0;
            prev_q     <= '0;
            pend_val_q <= '0;
            pending_q  <= 1'b0;
            dropped_q  <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            char_idx_q <= char_idx_d;
            bit_idx_q  <= bit_idx_d;
            msg_q      <= msg_d;
            prev_q     <= a0;
            pend_val_q <= changed ? a0 : pend_val_q;
            pending_q  <= pending_d;
            dropped_q  <= dropped_d;
            tx_q       <= tx_d;
        end
    end

    assign tx      = tx_q;
    assign busy    = (state_q != IDLE);
    assign dropped = dropped_q;

endmodule

// File: tb/tb_a0_uart_tx.sv
// Bench for a0_uart_tx: table-driven messages, hand-written corner cases and
// random a0/reset traffic checked against a cycle-count + string reference model.
module tb_a0_uart_tx;

    localparam int CPB     = 4;
    localparam int MSG_CYC = 100 * CPB;
    localparam int FRAME   = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] a0  = 32'h0;
    logic        tx, busy, dropped;

    a0_uart_tx #(.DATA_WIDTH(32), .CLKS_PER_BIT(CPB)) dut (
        .clk    (clk),
        .rst    (rst),
        .a0     (a0),
        .tx     (tx),
        .busy   (busy),
        .dropped(dropped)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model: a message is a 100*CPB-cycle window; the line level at
    // offset t is read from the text "%08X\r\n" framed as start/8 data/stop.
    logic [31:0] m_prev = 32'h0, m_pend_val = 32'h0, m_msg = 32'h0;
    logic        m_pending = 1'b0, m_drop = 1'b0;
    int          m_t = -1;
    logic        m_chg, m_ld;

    assign m_chg = (a0 != m_prev);
    assign m_ld  = (m_t < 0) && m_pending;

    always @(posedge clk) begin
        if (!rst) begin
            m_prev     <= 32'h0;
            m_pend_val <= 32'h0;
            m_msg      <= 32'h0;
            m_pending  <= 1'b0;
            m_drop     <= 1'b0;
            m_t        <= -1;
        end else begin
            m_drop <= m_chg && m_pending && !m_ld;
            if (m_ld) begin
                m_msg <= m_pend_val;
                m_t   <= 0;
            end else if (m_t >= 0) begin
                m_t <= (m_t + 1 == MSG_CYC) ? -1 : m_t + 1;
            end
            if (m_chg) begin
                m_prev     <= a0;
                m_pend_val <= a0;
                m_pending  <= 1'b1;
            end else if (m_ld) begin
                m_pending <= 1'b0;
            end
        end
    end

    function automatic logic model_tx(input int t, input logic [31:0] msg);
        string      s;
        int         c, b;
        logic [7:0] ch;
        if (t < 0) return 1'b1;
        s = $sformatf("%08x", msg);
        s = s.toupper();
        c = t / FRAME;
        b = (t / CPB) % 10;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        if (c == 8)      ch = 8'h0D;
        else if (c == 9) ch = 8'h0A;
        else             ch = s[c];
        return ch[b-1];
    endfunction

    int mm_cnt   = 0;
    int drop_cnt = 0;
    always @(negedge clk) begin
        if (tx !== model_tx(m_t, m_msg) || busy !== (m_t >= 0) || dropped !== m_drop)
            mm_cnt++;
        if (dropped === 1'b1) drop_cnt++;
    end

    // Waits for busy, then captures tx each cycle while busy and decodes it.
    task automatic run_msg(output int lat, output int len,
                           output logic [79:0] bytes, output logic [39:0] frame);
        logic cap [MSG_CYC + 64];
        logic [7:0] ch;
        lat = 0;
        len = 0;
        while (busy !== 1'b1 && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        while (busy === 1'b1 && len < MSG_CYC + 64) begin
            cap[len] = tx;
            @(negedge clk);
            len++;
        end
        for (int c = 0; c < 10; c++) begin
            for (int b = 0; b < 8; b++)
                ch[b] = (len >= MSG_CYC) ? cap[c*FRAME + (b+1)*CPB + CPB/2] : 1'bx;
            bytes[79 - 8*c -: 8] = ch;
        end
        for (int i = 0; i < 40; i++) frame[i] = (len >= 40) ? cap[i] : 1'bx;
    endtask

    typedef struct {
        logic [31:0] val;
        logic [79:0] exp_bytes;
        int          exp_lat;
        int          exp_len;
        bit          chk_frame;
    } vec_t;

    initial begin : main
        vec_t        vecs [4];
        int          lat, len, bad, mm_base, drop_base;
        logic [79:0] bytes;
        logic [39:0] frame, exp_frame;
        int          seq [10];

        vecs[0] = '{32'h1234ABCD, {"1234ABCD", 16'h0D0A}, 2, MSG_CYC, 1'b0};
        vecs[1] = '{32'h00000001, {"00000001", 16'h0D0A}, 2, MSG_CYC, 1'b1};
        vecs[2] = '{32'hFFFFFFFF, {"FFFFFFFF", 16'h0D0A}, 2, MSG_CYC, 1'b0};
        vecs[3] = '{32'h0F9A5C60, {"0F9A5C60", 16'h0D0A}, 2, MSG_CYC, 1'b0};
        // start, '0' = 0x30 LSB first, stop; each level held CPB cycles
        seq = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 1};
        for (int i = 0; i < 40; i++) exp_frame[i] = seq[i / CPB][0];

        // Idle after reset
        rst = 1'b0;
        a0  = 32'h0;
        repeat (4) @(negedge clk);
        check("reset_tx", 80'(tx), 80'(1));
        check("reset_busy", 80'(busy), 80'(0));
        check("reset_dropped", 80'(dropped), 80'(0));
        rst = 1'b1;
        bad = 0;
        repeat (2000) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || dropped !== 1'b0) bad++;
        end
        check("idle_quiet_cycles_bad", 80'(bad), 80'(0));

        // Table-driven single messages
        mm_base   = mm_cnt;
        drop_base = drop_cnt;
        for (int i = 0; i < 4; i++) begin
            a0 = vecs[i].val;
            run_msg(lat, len, bytes, frame);
            check($sformatf("vec%0d_latency", i), 80'(lat), 80'(vecs[i].exp_lat));
            check($sformatf("vec%0d_busy_len", i), 80'(len), 80'(vecs[i].exp_len));
            check($sformatf("vec%0d_bytes", i), bytes, vecs[i].exp_bytes);
            if (vecs[i].chk_frame)
                check($sformatf("vec%0d_first_frame", i), 80'(frame), 80'(exp_frame));
        end
        check("vec_no_drops", 80'(drop_cnt - drop_base), 80'(0));
        check("vec_model", 80'(mm_cnt - mm_base), 80'(0));

        // Coalescing: two changes during a message, only the last is sent
        mm_base = mm_cnt;
        a0 = 32'hCAFE0001;
        repeat (60) @(negedge clk);
        check("coal_busy_mid", 80'(busy), 80'(1));
        drop_base = drop_cnt;
        a0 = 32'h6;
        repeat (3) @(negedge clk);
        a0 = 32'h7;
        @(negedge clk);
        check("coal_drop_pulse", 80'(dropped), 80'(1));
        @(negedge clk);
        check("coal_drop_end", 80'(dropped), 80'(0));
        bad = 0;
        while (busy === 1'b1 && bad < MSG_CYC + 10) begin
            @(negedge clk);
            bad++;
        end
        check("coal_first_ends", 80'(busy), 80'(0));
        run_msg(lat, len, bytes, frame);
        check("coal_gap_cycles", 80'(lat), 80'(1));
        check("coal_bytes", bytes, {"00000007", 16'h0D0A});
        check("coal_drop_count", 80'(drop_cnt - drop_base), 80'(1));
        bad = 0;
        repeat (600) begin
            @(negedge clk);
            if (busy !== 1'b0) bad++;
        end
        check("coal_no_extra_msg", 80'(bad), 80'(0));

        // Change lands on the load edge: old value first, then the new one
        drop_base = drop_cnt;
        a0 = 32'h11111111;
        @(negedge clk);
        a0 = 32'h22222222;
        run_msg(lat, len, bytes, frame);
        check("simul_lat", 80'(lat), 80'(1));
        check("simul_first_bytes", bytes, {"11111111", 16'h0D0A});
        check("simul_gap_tx", 80'(tx), 80'(1));
        run_msg(lat, len, bytes, frame);
        check("simul_gap_cycles", 80'(lat), 80'(1));
        check("simul_second_bytes", bytes, {"22222222", 16'h0D0A});
        check("simul_second_len", 80'(len), 80'(MSG_CYC));
        check("simul_no_drop", 80'(drop_cnt - drop_base), 80'(0));

        // Reset during char 3, data bit 4, then resend from char 0
        a0  = 32'h89ABCDEF;
        bad = 0;
        while (busy !== 1'b1 && bad < 10) begin
            @(negedge clk);
            bad++;
        end
        repeat (3*FRAME + 5*CPB + 1) @(negedge clk);
        check("rstmid_busy_before", 80'(busy), 80'(1));
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_tx", 80'(tx), 80'(1));
        check("rstmid_busy", 80'(busy), 80'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_msg(lat, len, bytes, frame);
        check("rstmid_resend_lat", 80'(lat), 80'(2));
        check("rstmid_resend_bytes", bytes, {"89ABCDEF", 16'h0D0A});
        check("rstmid_resend_len", 80'(len), 80'(MSG_CYC));
        check("corner_model", 80'(mm_cnt - mm_base), 80'(0));

        // Random traffic against the model
        for (int it = 0; it < 8; it++) begin
            mm_base = mm_cnt;
            for (int k = 0; k < 10; k++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r == 0) begin
                    rst = 1'b0;
                    repeat ($urandom_range(1, 2)) @(negedge clk);
                    rst = 1'b1;
                end else if (r < 4) begin
                    a0 = 32'($urandom_range(0, 3));
                end else begin
                    a0 = $urandom();
                end
                repeat ($urandom_range(1, 250)) @(negedge clk);
            end
            check($sformatf("rand_model_seg%0d", it), 80'(mm_cnt - mm_base), 80'(0));
        end

        repeat (MSG_CYC + 20) @(negedge clk);
        check("drain_idle", 80'(busy), 80'(0));
        check("model_total", 80'(mm_cnt), 80'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

endmodule
